// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: scoreboard-driven stall, flush and forwarding control for the MIPS pipeline
module hazard_forward_unit #(
    parameter int ADDR_W    = 5,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int CNT_W     = 16,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs_i,
    input  logic [ADDR_W-1:0] id_rt_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic              id_wr_en_i,
    input  logic [ADDR_W-1:0] id_rd_i,
    input  logic              id_is_load_i,
    input  logic              id_branch_i,
    input  logic              branch_taken_i,
    output logic              stall_o,
    output logic              bubble_o,
    output logic              flush_o,
    output logic [SEL_W-1:0]  fwd_a_o,
    output logic [SEL_W-1:0]  fwd_b_o,
    output logic [SEL_W-1:0]  fwd_id_a_o,
    output logic [SEL_W-1:0]  fwd_id_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);
    logic [FWD_DEPTH:0] sb_v_q, sb_ld_q;
    logic [ADDR_W-1:0]  sb_rd_q [FWD_DEPTH+1];
    logic               ex_urs_q, ex_urt_q;
    logic [ADDR_W-1:0]  ex_rs_q, ex_rt_q;
    logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q, stall_cnt_d, flush_cnt_d;
    logic               hit_a, hit_b, slow_ld, load_use, br_stall, stall, flush;
    logic               s0_go, s0_v_d, s0_ld_d;
    logic [SEL_W-1:0]   fa, fb, fia, fib;

    // Scan oldest to youngest so the youngest matching producer is the last one written
    always_comb begin
        load_use = 1'b0;
        br_stall = 1'b0;
        hit_a    = 1'b0;
        hit_b    = 1'b0;
        slow_ld  = 1'b0;
        fa       = '0;
        fb       = '0;
        fia      = '0;
        fib      = '0;
        for (int k = FWD_DEPTH; k >= 0; k--) begin
            hit_a   = sb_v_q[k] && id_uses_rs_i && sb_rd_q[k] == id_rs_i;
            hit_b   = sb_v_q[k] && id_uses_rt_i && sb_rd_q[k] == id_rt_i;
            slow_ld = sb_ld_q[k] && k <= LOAD_LAT;
            if ((hit_a || hit_b) && sb_ld_q[k] && k < LOAD_LAT) load_use = 1'b1;
            if ((hit_a || hit_b) && id_branch_i && (k == 0 || slow_ld)) br_stall = 1'b1;
            if (k > 0) begin
                if (sb_v_q[k] && ex_urs_q && sb_rd_q[k] == ex_rs_q) fa = SEL_W'(k);
                if (sb_v_q[k] && ex_urt_q && sb_rd_q[k] == ex_rt_q) fb = SEL_W'(k);
                if (hit_a && !slow_ld) fia = SEL_W'(k);
                if (hit_b && !slow_ld) fib = SEL_W'(k);
            end
        end
        stall       = id_valid_i && (load_use || br_stall);
        flush       = id_valid_i && id_branch_i && branch_taken_i && !stall;
        s0_go       = id_valid_i && !stall;
        s0_v_d      = s0_go && id_wr_en_i && id_rd_i != '0;
        s0_ld_d     = s0_go && id_is_load_i;
        stall_cnt_d = (stall_o && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush_o && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    // Reset forces every output low, including the paths fed straight from the ID inputs
    always_comb begin
        stall_o     = !rst_i && stall;
        bubble_o    = !rst_i && stall;
        flush_o     = !rst_i && flush;
        fwd_a_o     = rst_i ? '0 : fa;
        fwd_b_o     = rst_i ? '0 : fb;
        fwd_id_a_o  = (!rst_i && id_valid_i && id_branch_i) ? fia : '0;
        fwd_id_b_o  = (!rst_i && id_valid_i && id_branch_i) ? fib : '0;
        stall_cnt_o = rst_i ? '0 : stall_cnt_q;
        flush_cnt_o = rst_i ? '0 : flush_cnt_q;
    end

    // Scoreboard shifts every cycle; a stalled cycle pushes a bubble into the EX slot
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_v_q   <= '0;
            sb_ld_q  <= '0;
            for (int k = 0; k <= FWD_DEPTH; k++) sb_rd_q[k] <= '0;
            ex_urs_q <= 1'b0;
            ex_urt_q <= 1'b0;
            ex_rs_q  <= '0;
            ex_rt_q  <= '0;
        end else begin
            sb_v_q     <= {sb_v_q[FWD_DEPTH-1:0], s0_v_d};
            sb_ld_q    <= {sb_ld_q[FWD_DEPTH-1:0], s0_ld_d};
            sb_rd_q[0] <= id_rd_i;
            for (int k = 1; k <= FWD_DEPTH; k++) sb_rd_q[k] <= sb_rd_q[k-1];
            ex_urs_q   <= s0_go && id_uses_rs_i;
            ex_urt_q   <= s0_go && id_uses_rt_i;
            ex_rs_q    <= id_rs_i;
            ex_rt_q    <= id_rt_i;
        end
    end

    // Saturating stall and flush event counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed program snippets plus random instruction streams against a distance-based model
module tb_hazard_forward_unit;
    localparam int AW = 5;
    localparam int FD = 2;
    localparam int LL = 1;
    localparam int CW = 16;
    localparam int SW = $clog2(FD + 1);

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          id_valid_i, id_uses_rs_i, id_uses_rt_i, id_wr_en_i, id_is_load_i, id_branch_i, branch_taken_i;
    logic [AW-1:0] id_rs_i, id_rt_i, id_rd_i;
    logic          stall_o, bubble_o, flush_o;
    logic [SW-1:0] fwd_a_o, fwd_b_o, fwd_id_a_o, fwd_id_b_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    always #5 clk_i = ~clk_i;

    hazard_forward_unit #(.ADDR_W(AW), .FWD_DEPTH(FD), .LOAD_LAT(LL), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i), .id_wr_en_i(id_wr_en_i),
        .id_rd_i(id_rd_i), .id_is_load_i(id_is_load_i), .id_branch_i(id_branch_i),
        .branch_taken_i(branch_taken_i), .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .fwd_id_a_o(fwd_id_a_o), .fwd_id_b_o(fwd_id_b_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    // Instructions past ID, youngest first: hist[d] is the instruction d stages beyond EX entry
    typedef struct packed {
        logic          wr;
        logic [AW-1:0] rd;
        logic          ld;
        logic          urs;
        logic [AW-1:0] rs;
        logic          urt;
        logic [AW-1:0] rt;
    } rec_t;

    rec_t hist[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   m_stall_cnt, m_flush_cnt;
    logic e_stall, e_flush;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist = {};
        for (int i = 0; i <= FD; i++) hist.push_back('0);
        m_stall_cnt = 0;
        m_flush_cnt = 0;
        e_stall = 1'b0;
        e_flush = 1'b0;
    endtask

    // Distance of the youngest in-flight writer of r, searching from distance 'from'; -1 if none
    function automatic int youngest(input logic [AW-1:0] r, input int from);
        for (int k = from; k <= FD; k++) if (hist[k].wr && hist[k].rd == r) return k;
        return -1;
    endfunction

    // A consumer in ID needs its producer at least 'need' stages away now:
    // EX operands are read next cycle, branch operands now; loads become usable LL stages later than ALU results
    function automatic logic src_stall(input logic u, input logic [AW-1:0] r);
        int y = youngest(r, 0);
        int need;
        if (!u || y < 0) return 1'b0;
        need = (id_branch_i ? 1 : 0) + (hist[y].ld ? LL : 0);
        return y < need;
    endfunction

    function automatic int fwd_dist(input logic u, input logic [AW-1:0] r);
        int y = youngest(r, 1);
        return (u && y > 0) ? y : 0;
    endfunction

    task automatic settle();
        @(negedge clk_i);
        e_stall = id_valid_i && (src_stall(id_uses_rs_i, id_rs_i) || src_stall(id_uses_rt_i, id_rt_i));
        e_flush = id_valid_i && id_branch_i && branch_taken_i && !e_stall;
        chk("stall", stall_o, e_stall);
        chk("bubble", bubble_o, e_stall);
        chk("flush", flush_o, e_flush);
        chk("fwd_a", fwd_a_o, fwd_dist(hist[0].urs, hist[0].rs));
        chk("fwd_b", fwd_b_o, fwd_dist(hist[0].urt, hist[0].rt));
        if (id_valid_i && id_branch_i && !e_stall) begin
            chk("fwd_id_a", fwd_id_a_o, fwd_dist(id_uses_rs_i, id_rs_i));
            chk("fwd_id_b", fwd_id_b_o, fwd_dist(id_uses_rt_i, id_rt_i));
        end
        chk("stall_cnt", stall_cnt_o, m_stall_cnt);
        chk("flush_cnt", flush_cnt_o, m_flush_cnt);
    endtask

    task automatic adv();
        rec_t r;
        @(posedge clk_i);
        r = '0;
        if (id_valid_i && !e_stall) begin
            r.wr  = id_wr_en_i && id_rd_i != '0;
            r.rd  = id_rd_i;
            r.ld  = id_is_load_i;
            r.urs = id_uses_rs_i;
            r.rs  = id_rs_i;
            r.urt = id_uses_rt_i;
            r.rt  = id_rt_i;
        end
        hist.push_front(r);
        void'(hist.pop_back());
        if (e_stall && m_stall_cnt < (1 << CW) - 1) m_stall_cnt++;
        if (e_flush && m_flush_cnt < (1 << CW) - 1) m_flush_cnt++;
        #1;
    endtask

    task automatic drive(input logic v, input logic urs, input int rs, input logic urt, input int rt,
                         input logic wr, input int rd, input logic ld, input logic br, input logic tk);
        id_valid_i     = v;
        id_uses_rs_i   = urs;
        id_rs_i        = AW'(rs);
        id_uses_rt_i   = urt;
        id_rt_i        = AW'(rt);
        id_wr_en_i     = wr;
        id_rd_i        = AW'(rd);
        id_is_load_i   = ld;
        id_branch_i    = br;
        branch_taken_i = tk;
    endtask

    task automatic alu(input int rd, input int rs, input int rt);
        drive(1, 1, rs, 1, rt, 1, rd, 0, 0, 0);
    endtask
    task automatic lw(input int rd, input int base);
        drive(1, 1, base, 0, 0, 1, rd, 1, 0, 0);
    endtask
    task automatic beq(input int rs, input int rt, input logic tk);
        drive(1, 1, rs, 1, rt, 0, 0, 0, 1, tk);
    endtask
    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Outputs held low during reset even with a taken branch sitting in ID
        beq(1, 1, 1);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_flush", flush_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_fwd_a", fwd_a_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        model_reset();
        nop();
        rst_i = 1'b0;
        // add $3 ; sub $5,$3,$4 ; or $6,$3,$0
        alu(3, 1, 2); settle(); chk("lit_add_nostall", stall_o, 0); adv();
        alu(5, 3, 4); settle(); adv();
        alu(6, 3, 0); settle(); chk("lit_sub_fwd_a", fwd_a_o, 1); adv();
        nop();        settle(); chk("lit_or_fwd_a", fwd_a_o, 2); adv();
        // lw $2 ; add $4,$2,$2
        lw(2, 1);     settle(); adv();
        alu(4, 2, 2); settle(); chk("lit_lu_stall", stall_o, 1); chk("lit_lu_bubble", bubble_o, 1); adv();
        settle(); chk("lit_lu_release", stall_o, 0); adv();
        nop();        settle(); chk("lit_lu_fwd_a", fwd_a_o, 2); chk("lit_lu_fwd_b", fwd_b_o, 2);
        chk("lit_stall_cnt1", stall_cnt_o, 1); adv();
        // $0 is never forwarded
        alu(0, 1, 2); settle(); adv();
        alu(5, 0, 0); settle(); chk("lit_r0_nostall", stall_o, 0); adv();
        nop();        settle(); chk("lit_r0_fwd_a", fwd_a_o, 0); chk("lit_r0_fwd_b", fwd_b_o, 0); adv();
        // add $4 ; beq $4,$4 taken
        alu(4, 1, 2); settle(); adv();
        beq(4, 4, 1); settle(); chk("lit_br_stall", stall_o, 1); chk("lit_br_noflush", flush_o, 0); adv();
        settle(); chk("lit_br_fwd_id", fwd_id_a_o, 1); chk("lit_br_flush", flush_o, 1); adv();
        nop();        settle(); chk("lit_flush_cnt", flush_cnt_o, 1); adv();
        // add $7 ; add $7 ; add $8,$7,$7 ; lw $9 ; beq $9
        alu(7, 1, 2); settle(); adv();
        alu(7, 3, 4); settle(); adv();
        alu(8, 7, 7); settle(); adv();
        nop();        settle(); chk("lit_young_a", fwd_a_o, 1); chk("lit_young_b", fwd_b_o, 1); adv();
        lw(9, 1);     settle(); adv();
        beq(9, 9, 0); settle(); chk("lit_ldbr_stall1", stall_o, 1); adv();
        settle(); chk("lit_ldbr_stall2", stall_o, 1); adv();
        settle(); chk("lit_ldbr_go", stall_o, 0); chk("lit_ldbr_fwd_id", fwd_id_a_o, 2);
        chk("lit_stall_cnt4", stall_cnt_o, 4); adv();
        // Reset asserted during a load-use stall
        lw(2, 1);     settle(); adv();
        alu(4, 2, 2); settle(); chk("lit_pre_rst_stall", stall_o, 1);
        rst_i = 1'b1;
        #1;
        chk("lit_rst_stall_drop", stall_o, 0);
        chk("lit_rst_stall_cnt", stall_cnt_o, 0);
        chk("lit_rst_flush_cnt", flush_cnt_o, 0);
        @(posedge clk_i);
        #1;
        model_reset();
        rst_i = 1'b0;
        settle(); chk("lit_post_rst_nostall", stall_o, 0); adv();
        // Random instruction stream; a stalled instruction stays in ID
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst_i = 1'b1;
                @(posedge clk_i);
                #1;
                model_reset();
                rst_i = 1'b0;
            end
            if (!e_stall) begin
                if ($urandom_range(0, 3) == 0)
                    drive($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 3),
                          $urandom_range(0, 1), $urandom_range(0, 3), 0, $urandom_range(0, 3),
                          0, 1, $urandom_range(0, 1));
                else
                    drive($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 3),
                          $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3), $urandom_range(0, 2) == 0, 0, $urandom_range(0, 1));
            end
            settle();
            adv();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
